// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared constants and head FSM states for the ROB.
// Optional operand forwarding is enabled with the ROB_FWD_EN macro.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;

  localparam logic STORE    = 1'b1;
  localparam logic NOT_JUMP = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1
  } head_state_t;

  function automatic int tag_bits(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, writeback, commit, store and flush buses.
// slave is the ROB side, master is the pipeline side.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = tag_bits(ROB_DEPTH)
);

  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [REG_W-1:0]  alloc_rd;
  logic              alloc_is_store;
  logic              alloc_is_branch;
  logic              alloc_pred_taken;

  logic              ex_valid;
  logic [TAG_W-1:0]  ex_tag;
  logic [DATA_W-1:0] ex_data;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;

  logic              lsb_valid;
  logic [TAG_W-1:0]  lsb_tag;
  logic [DATA_W-1:0] lsb_data;

  logic              commit_valid;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;

  logic              store_valid;
  logic [TAG_W-1:0]  store_tag;
  logic              store_done;

  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic [TAG_W-1:0]  count;

  modport slave (
    input  alloc_valid, alloc_rd,
    input  alloc_is_store, alloc_is_branch,
    input  alloc_pred_taken,
    input  ex_valid, ex_tag, ex_data,
    input  ex_taken, ex_target,
    input  lsb_valid, lsb_tag, lsb_data,
    input  store_done,
    output alloc_ready, alloc_tag,
    output commit_valid, commit_rd,
    output commit_data, commit_tag,
    output store_valid, store_tag,
    output flush, flush_pc, count
  );

  modport master (
    output alloc_valid, alloc_rd,
    output alloc_is_store, alloc_is_branch,
    output alloc_pred_taken,
    output ex_valid, ex_tag, ex_data,
    output ex_taken, ex_target,
    output lsb_valid, lsb_tag, lsb_data,
    output store_done,
    input  alloc_ready, alloc_tag,
    input  commit_valid, commit_rd,
    input  commit_data, commit_tag,
    input  store_valid, store_tag,
    input  flush, flush_pc, count
  );

endinterface

// File: rtl/reorder_buffer_query.sv
// rob_query: tag lookup returning a ready result, bypassing this
// cycle's EX/SLB writeback (EX has priority over SLB).
module rob_query
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = 32,
  parameter int TAG_W  = tag_bits(DEPTH)
) (
  input  logic [TAG_W-1:0]  q_tag,
  input  logic [DEPTH-1:0]  busy,
  input  logic [DEPTH-1:0]  done,
  input  logic [DATA_W-1:0] data [DEPTH],
  input  logic              ex_hit,
  input  logic [TAG_W-1:0]  ex_tag,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              lsb_hit,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_data,
  output logic              hit,
  output logic [DATA_W-1:0] q_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TAG_MAX = TAG_W'(DEPTH);

  logic [PTR_W-1:0] idx;
  logic             ok;

  assign idx = PTR_W'(q_tag - 1'b1);
  assign ok  = (q_tag != '0) && (q_tag <= TAG_MAX);

  always_comb begin
    hit    = 1'b0;
    q_data = '0;
    if (ok) begin
      if (ex_hit && ex_tag == q_tag) begin
        hit    = 1'b1;
        q_data = ex_data;
      end else if (lsb_hit && lsb_tag == q_tag) begin
        hit    = 1'b1;
        q_data = lsb_data;
      end else if (busy[idx] && done[idx]) begin
        hit    = 1'b1;
        q_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement, store handshake and mispredict
// flush. Define ROB_FWD_EN to add the q1/q2 operand lookup ports.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = tag_bits(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
`ifdef ROB_FWD_EN
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_hit,
  output logic [DATA_W-1:0] q1_data,
  output logic              q2_hit,
  output logic [DATA_W-1:0] q2_data,
`endif
  reorder_buffer_if.slave   rob
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TAG_MAX = TAG_W'(DEPTH);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  is_store;
  logic [DEPTH-1:0]  is_branch;
  logic [DEPTH-1:0]  pred;
  logic [DEPTH-1:0]  taken;
  logic [REG_W-1:0]  rd     [DEPTH];
  logic [DATA_W-1:0] data   [DEPTH];
  logic [ADDR_W-1:0] target [DEPTH];

  logic [PTR_W-1:0]  head, tail;
  logic [TAG_W-1:0]  count, head_tag;
  head_state_t       state_q, state_d;

  logic             full, alloc_fire;
  logic             retire, store_start, mispredict;
  logic             ex_hit, lsb_hit;
  logic [PTR_W-1:0] ex_idx, lsb_idx;

  assign full     = count == TAG_MAX;
  assign head_tag = TAG_W'(head) + TAG_W'(1);
  assign ex_idx   = PTR_W'(rob.ex_tag - 1'b1);
  assign lsb_idx  = PTR_W'(rob.lsb_tag - 1'b1);

  // Writebacks to tag 0, out-of-range or idle entries are dropped.
  assign ex_hit = rdy && rob.ex_valid
               && (rob.ex_tag != '0)
               && (rob.ex_tag <= TAG_MAX)
               && busy[ex_idx];
  assign lsb_hit = rdy && rob.lsb_valid
                && (rob.lsb_tag != '0)
                && (rob.lsb_tag <= TAG_MAX)
                && busy[lsb_idx];

  assign rob.alloc_ready = !full && !rob.flush
                        && !mispredict;
  assign rob.alloc_tag   = TAG_W'(tail) + TAG_W'(1);
  assign rob.count       = count;
  assign alloc_fire      = rdy && rob.alloc_valid
                        && rob.alloc_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    store_start = 1'b0;
    if (rdy) begin
      unique case (state_q)
        ST_IDLE: begin
          if (busy[head] && done[head]) begin
            if (is_store[head] == STORE) begin
              store_start = 1'b1;
              state_d     = ST_STORE;
            end else begin
              retire = 1'b1;
            end
          end
        end
        ST_STORE: begin
          if (rob.store_done) begin
            retire  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign mispredict = retire
                   && (state_q == ST_IDLE)
                   && is_branch[head]
                   && (taken[head] != pred[head]);

  always_ff @(posedge clk) begin
    if (rst || mispredict) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
    end else begin
      if (retire) begin
        head       <= head + 1'b1;
        busy[head] <= 1'b0;
      end
      if (alloc_fire) begin
        tail       <= tail + 1'b1;
        busy[tail] <= 1'b1;
      end
      count <= count + TAG_W'(alloc_fire)
                     - TAG_W'(retire);
    end
  end

  // Payload needs no reset: it is only read behind busy.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      done[tail]      <= 1'b0;
      rd[tail]        <= rob.alloc_rd;
      is_store[tail]  <= rob.alloc_is_store;
      is_branch[tail] <= rob.alloc_is_branch;
      pred[tail]      <= rob.alloc_pred_taken;
      taken[tail]     <= NOT_JUMP;
    end
    if (lsb_hit) begin
      done[lsb_idx] <= 1'b1;
      data[lsb_idx] <= rob.lsb_data;
    end
    if (ex_hit) begin
      done[ex_idx]   <= 1'b1;
      data[ex_idx]   <= rob.ex_data;
      taken[ex_idx]  <= rob.ex_taken;
      target[ex_idx] <= rob.ex_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rob.commit_valid <= 1'b0;
      rob.commit_rd    <= '0;
      rob.commit_data  <= '0;
      rob.commit_tag   <= '0;
      rob.flush        <= 1'b0;
      rob.flush_pc     <= '0;
    end else if (!rdy) begin
      rob.commit_valid <= 1'b0;
      rob.flush        <= 1'b0;
    end else begin
      rob.commit_valid <= retire
                       && (is_store[head] != STORE)
                       && (rd[head] != '0);
      rob.flush <= mispredict;
      if (retire) begin
        rob.commit_rd   <= rd[head];
        rob.commit_data <= data[head];
        rob.commit_tag  <= head_tag;
      end
      if (mispredict) rob.flush_pc <= target[head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rob.store_valid <= 1'b0;
      rob.store_tag   <= '0;
    end else if (store_start) begin
      rob.store_valid <= 1'b1;
      rob.store_tag   <= head_tag;
    end else if (retire && state_q == ST_STORE) begin
      rob.store_valid <= 1'b0;
    end
  end

`ifdef ROB_FWD_EN
  rob_query #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) u_q1 (
    .q_tag   (q1_tag),
    .busy    (busy),
    .done    (done),
    .data    (data),
    .ex_hit  (ex_hit),
    .ex_tag  (rob.ex_tag),
    .ex_data (rob.ex_data),
    .lsb_hit (lsb_hit),
    .lsb_tag (rob.lsb_tag),
    .lsb_data(rob.lsb_data),
    .hit     (q1_hit),
    .q_data  (q1_data)
  );

  rob_query #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) u_q2 (
    .q_tag   (q2_tag),
    .busy    (busy),
    .done    (done),
    .data    (data),
    .ex_hit  (ex_hit),
    .ex_tag  (rob.ex_tag),
    .ex_data (rob.ex_data),
    .lsb_hit (lsb_hit),
    .lsb_tag (rob.lsb_tag),
    .lsb_data(rob.lsb_data),
    .hit     (q2_hit),
    .q_data  (q2_data)
  );
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of allocation, retirement, stores,
// mispredict flush, wrap-around, rdy freeze and ROB_FWD_EN lookups.
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reorder_buffer_if rob_bus ();

`ifdef ROB_FWD_EN
  logic [4:0]  q1_tag, q2_tag;
  logic        q1_hit, q2_hit;
  logic [31:0] q1_data, q2_data;
`endif

  reorder_buffer #(.DEPTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .rdy    (rdy),
`ifdef ROB_FWD_EN
    .q1_tag (q1_tag),
    .q2_tag (q2_tag),
    .q1_hit (q1_hit),
    .q1_data(q1_data),
    .q2_hit (q2_hit),
    .q2_data(q2_data),
`endif
    .rob    (rob_bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rob_bus.alloc_valid      = 1'b0;
    rob_bus.alloc_rd         = '0;
    rob_bus.alloc_is_store   = 1'b0;
    rob_bus.alloc_is_branch  = 1'b0;
    rob_bus.alloc_pred_taken = 1'b0;
    rob_bus.ex_valid         = 1'b0;
    rob_bus.ex_tag           = '0;
    rob_bus.ex_data          = '0;
    rob_bus.ex_taken         = 1'b0;
    rob_bus.ex_target        = '0;
    rob_bus.lsb_valid        = 1'b0;
    rob_bus.lsb_tag          = '0;
    rob_bus.lsb_data         = '0;
    rob_bus.store_done       = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic st,
                       input logic br, input logic pr);
    rob_bus.alloc_valid      = 1'b1;
    rob_bus.alloc_rd         = rd;
    rob_bus.alloc_is_store   = st;
    rob_bus.alloc_is_branch  = br;
    rob_bus.alloc_pred_taken = pr;
  endtask

  task automatic ex(input logic [4:0] tag, input logic [31:0] d);
    rob_bus.ex_valid = 1'b1;
    rob_bus.ex_tag   = tag;
    rob_bus.ex_data  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cur, nxt;
    rdy = 1'b1;
`ifdef ROB_FWD_EN
    q1_tag = '0;
    q2_tag = '0;
`endif
    idle();
    do_reset();
    chk("rst_count", rob_bus.count, 0);
    chk("rst_commit_valid", rob_bus.commit_valid, 0);
    chk("rst_commit_tag", rob_bus.commit_tag, 0);
    chk("rst_store_valid", rob_bus.store_valid, 0);
    chk("rst_store_tag", rob_bus.store_tag, 0);
    chk("rst_flush", rob_bus.flush, 0);
    chk("rst_flush_pc", rob_bus.flush_pc, 0);
    chk("rst_alloc_ready", rob_bus.alloc_ready, 1);
    chk("rst_alloc_tag", rob_bus.alloc_tag, 1);

    // Fill all 16 entries, write back in reverse order
    for (int i = 1; i <= 16; i++) begin
      alloc(5'(i), 1'b0, 1'b0, 1'b0);
      #1 chk("fill_alloc_tag", rob_bus.alloc_tag, i);
      tick();
    end
    chk("full_count", rob_bus.count, 16);
    chk("full_ready", rob_bus.alloc_ready, 0);
    tick();
    chk("full_refused", rob_bus.count, 16);
    idle();
    for (int k = 16; k >= 2; k--) begin
      ex(5'(k), 32'(256 + k));
      tick();
    end
    chk("ooo_no_commit", rob_bus.commit_valid, 0);
    ex(5'd1, 32'h101);
    tick();
    idle();
    chk("head_done_no_commit_yet", rob_bus.commit_valid, 0);
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("seq_valid", rob_bus.commit_valid, 1);
      chk("seq_tag", rob_bus.commit_tag, t);
      chk("seq_rd", rob_bus.commit_rd, t);
      chk("seq_data", rob_bus.commit_data, 256 + t);
    end
    chk("drain_count", rob_bus.count, 0);
    tick();
    chk("drain_idle", rob_bus.commit_valid, 0);

    // Store at head, acknowledged after five store_valid cycles
    alloc(5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    rob_bus.lsb_valid = 1'b1;
    rob_bus.lsb_tag   = 5'd1;
    rob_bus.lsb_data  = 32'habc;
    tick();
    idle();
    chk("st_not_yet", rob_bus.store_valid, 0);
    tick();
    chk("st_valid", rob_bus.store_valid, 1);
    chk("st_tag", rob_bus.store_tag, 1);
    for (int w = 0; w < 4; w++) begin
      tick();
      chk("st_hold", rob_bus.store_valid, 1);
      chk("st_no_commit", rob_bus.commit_valid, 0);
    end
    rob_bus.store_done = 1'b1;
    tick();
    idle();
    chk("st_ack_drop", rob_bus.store_valid, 0);
    chk("st_ack_no_commit", rob_bus.commit_valid, 0);
    chk("st_ack_count", rob_bus.count, 0);
    chk("st_head_moved", rob_bus.alloc_tag, 2);

    // Mispredicted branch at tag 3 with younger tags 4..6
    do_reset();
    chk("rst2_count", rob_bus.count, 0);
    alloc(5'd1, 1'b0, 1'b0, 1'b0); tick();
    alloc(5'd2, 1'b0, 1'b0, 1'b0); tick();
    alloc(5'd0, 1'b0, 1'b1, 1'b0); tick();
    alloc(5'd4, 1'b0, 1'b0, 1'b0); tick();
    alloc(5'd5, 1'b0, 1'b0, 1'b0); tick();
    alloc(5'd6, 1'b0, 1'b0, 1'b0); tick();
    idle();
    chk("br_count", rob_bus.count, 6);
    ex(5'd4, 32'h44); tick();
    ex(5'd5, 32'h55); tick();
    ex(5'd6, 32'h66); tick();
    ex(5'd1, 32'h11); tick();
    ex(5'd2, 32'h22); tick();
    chk("br_c1_tag", rob_bus.commit_tag, 1);
    chk("br_c1_rd", rob_bus.commit_rd, 1);
    ex(5'd3, 32'h0);
    rob_bus.ex_taken  = 1'b1;
    rob_bus.ex_target = 32'h1000;
    tick();
    chk("br_c2_tag", rob_bus.commit_tag, 2);
    chk("br_c2_data", rob_bus.commit_data, 32'h22);
    idle();
    alloc(5'd9, 1'b0, 1'b0, 1'b0);
    #1 chk("br_alloc_refused", rob_bus.alloc_ready, 0);
    tick();
    idle();
    chk("br_flush", rob_bus.flush, 1);
    chk("br_flush_pc", rob_bus.flush_pc, 32'h1000);
    chk("br_flush_count", rob_bus.count, 0);
    chk("br_no_rd_commit", rob_bus.commit_valid, 0);
    chk("br_flush_ready", rob_bus.alloc_ready, 0);
    tick();
    chk("br_flush_pulse", rob_bus.flush, 0);
    chk("br_after_ready", rob_bus.alloc_ready, 1);
    chk("br_after_tag", rob_bus.alloc_tag, 1);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("br_squashed", rob_bus.commit_valid, 0);
    end

    // Steady-state alloc/commit pairs across the wrap
    alloc(5'd1, 1'b0, 1'b0, 1'b0);
    tick();
    cur = 1;
    for (int i = 0; i < 40; i++) begin
      idle();
      ex(5'(cur), 32'(32'h2000 + i));
      tick();
      chk("wrap_count_a", rob_bus.count, 1);
      idle();
      nxt = (cur == 16) ? 1 : cur + 1;
      alloc(5'(nxt), 1'b0, 1'b0, 1'b0);
      #1 chk("wrap_alloc_tag", rob_bus.alloc_tag, nxt);
      tick();
      chk("wrap_valid", rob_bus.commit_valid, 1);
      chk("wrap_tag", rob_bus.commit_tag, cur);
      chk("wrap_rd", rob_bus.commit_rd, cur);
      chk("wrap_data", rob_bus.commit_data, 32'h2000 + i);
      chk("wrap_count_b", rob_bus.count, 1);
      cur = nxt;
    end
    idle();

    // Concurrent EX/SLB writebacks with alloc and retire
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      alloc(5'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    ex(5'd1, 32'h11);
    tick();
    chk("cc_no_commit", rob_bus.commit_valid, 0);
    idle();
    ex(5'd2, 32'h22);
    rob_bus.lsb_valid = 1'b1;
    rob_bus.lsb_tag   = 5'd5;
    rob_bus.lsb_data  = 32'h55;
    alloc(5'd6, 1'b0, 1'b0, 1'b0);
    tick();
    chk("cc_count", rob_bus.count, 5);
    chk("cc_c1_tag", rob_bus.commit_tag, 1);
    chk("cc_c1_data", rob_bus.commit_data, 32'h11);
    idle();
    ex(5'd3, 32'h33);
    tick();
    chk("cc_c2_tag", rob_bus.commit_tag, 2);
    chk("cc_c2_data", rob_bus.commit_data, 32'h22);
    chk("cc_c2_count", rob_bus.count, 4);
    ex(5'd4, 32'h44);
    tick();
    chk("cc_c3_data", rob_bus.commit_data, 32'h33);
    idle();
    tick();
    chk("cc_c4_data", rob_bus.commit_data, 32'h44);
    tick();
    chk("cc_c5_tag", rob_bus.commit_tag, 5);
    chk("cc_c5_data", rob_bus.commit_data, 32'h55);
    tick();
    chk("cc_tag6_wait", rob_bus.commit_valid, 0);
    chk("cc_tag6_count", rob_bus.count, 1);
    ex(5'd6, 32'h66);
    rob_bus.lsb_valid = 1'b1;
    rob_bus.lsb_tag   = 5'd6;
    rob_bus.lsb_data  = 32'h99;
    tick();
    idle();
    tick();
    chk("cc_ex_wins_tag", rob_bus.commit_tag, 6);
    chk("cc_ex_wins_data", rob_bus.commit_data, 32'h66);
    chk("cc_empty", rob_bus.count, 0);

    // rdy low freezes retirement and drops commit_valid
    alloc(5'd7, 1'b0, 1'b0, 1'b0);
    #1 chk("rdy_alloc_tag", rob_bus.alloc_tag, 7);
    tick();
    idle();
    ex(5'd7, 32'h77);
`ifdef ROB_FWD_EN
    q1_tag = 5'd7;
    q2_tag = 5'd0;
    #1;
    chk("fwd_q1_hit", q1_hit, 1);
    chk("fwd_q1_data", q1_data, 32'h77);
    chk("fwd_q2_hit", q2_hit, 0);
`endif
    tick();
    idle();
`ifdef ROB_FWD_EN
    #1;
    chk("fwd_q1_stored", q1_hit, 1);
    chk("fwd_q1_sdata", q1_data, 32'h77);
`endif
    rdy = 1'b0;
    tick();
    chk("rdy_freeze_cv", rob_bus.commit_valid, 0);
    chk("rdy_freeze_cnt", rob_bus.count, 1);
    tick();
    chk("rdy_freeze_cv2", rob_bus.commit_valid, 0);
    rdy = 1'b1;
    tick();
    chk("rdy_resume_cv", rob_bus.commit_valid, 1);
    chk("rdy_resume_tag", rob_bus.commit_tag, 7);
    chk("rdy_resume_data", rob_bus.commit_data, 32'h77);
    chk("rdy_resume_cnt", rob_bus.count, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
